// File: rtl/sb_tx_msg_fifo.sv
// ---------------------------------------------------------------------------
// sb_tx_msg_fifo
//
// Sideband TX message FIFO between the RDI sideband packer and the TX
// serializer. Every no-data message header is followed by a 64-bit all-zero
// pad word, so each message occupies 128 bits in the stream. Pads are
// counted while headers arrive and inserted into storage on idle write
// cycles. When a popped word is all zeros, that is flagged so the serializer
// skips it and the credit loop can release on it.
//
// Ports:
//   i_clk              clock
//   i_rst_n            asynchronous active-low reset
//   i_wr_en            write strobe for one word from the packer
//   i_wr_data          word to store
//   i_wr_is_hdr        word is a message header
//   i_wr_has_data      with i_wr_is_hdr: 1 = data follows, 0 = no-data message
//   i_rd_en            read request from the serializer
//   o_fifo_data        registered word last popped
//   o_dont_send_zeros  popped word is all zeros
//   o_empty            no stored words and no pending pads
//   o_full             stored word count equals DEPTH
//   o_count            stored words
//   o_overflow         sticky: a word or pad was lost
//   o_underflow        sticky: read attempted while storage was empty
// ---------------------------------------------------------------------------
module sb_tx_msg_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_is_hdr,
  input  logic              i_wr_has_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_fifo_data,
  output logic              o_dont_send_zeros,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [PEND_W-1:0] r_pend_cnt;
  logic [DATA_W-1:0] r_fifo_data;
  logic              r_dont_send_zeros;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_rd_accept;
  logic              w_can_store;
  logic              w_wr_word;
  logic              w_pad_store;
  logic              w_store;
  logic [DATA_W-1:0] w_store_data;
  logic              w_pad_due;
  logic              w_pend_sat;
  logic              w_lost;

  assign w_full      = (r_count == CNT_FULL);
  assign w_rd_accept = i_rd_en && (r_count != '0);
  // A pop in the same cycle frees the slot the write lands in.
  assign w_can_store = !w_full || w_rd_accept;
  assign w_wr_word   = i_wr_en && w_can_store;
  // Pads only fill otherwise idle write slots, so a real word is never delayed.
  assign w_pad_store = !i_wr_en && (r_pend_cnt != '0) && w_can_store;
  assign w_store     = w_wr_word || w_pad_store;
  assign w_store_data = i_wr_en ? i_wr_data : '0;

  // A no-data header owes a pad even when the header itself was dropped.
  assign w_pad_due  = i_wr_en && i_wr_is_hdr && !i_wr_has_data;
  assign w_pend_sat = w_pad_due && (r_pend_cnt == PEND_MAX);
  assign w_lost     = (i_wr_en && !w_can_store) || w_pend_sat;

  // Storage array without reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_store_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_pend_cnt        <= '0;
      r_fifo_data       <= '0;
      r_dont_send_zeros <= 1'b0;
      r_overflow        <= 1'b0;
      r_underflow       <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end

      if (w_rd_accept) begin
        // On a full write+read the slot is overwritten this edge; the
        // nonblocking read still returns the old head word.
        r_fifo_data       <= r_mem[r_rd_ptr];
        r_dont_send_zeros <= (r_mem[r_rd_ptr] == '0);
        r_rd_ptr          <= r_rd_ptr + PTR_ONE;
      end

      if (w_store && !w_rd_accept) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_store && w_rd_accept) begin
        r_count <= r_count - CNT_ONE;
      end

      // Increment and pad insertion are mutually exclusive (pad needs !i_wr_en).
      if (w_pad_due) begin
        if (!w_pend_sat) begin
          r_pend_cnt <= r_pend_cnt + PEND_ONE;
        end
      end else if (w_pad_store) begin
        r_pend_cnt <= r_pend_cnt - PEND_ONE;
      end

      if (w_lost) begin
        r_overflow <= 1'b1;
      end
      if (i_rd_en && (r_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_fifo_data       = r_fifo_data;
  assign o_dont_send_zeros = r_dont_send_zeros;
  assign o_count           = r_count;
  assign o_full            = w_full;
  assign o_empty           = (r_count == '0) && (r_pend_cnt == '0);
  assign o_overflow        = r_overflow;
  assign o_underflow       = r_underflow;

endmodule

// File: doc/sb_tx_msg_fifo.md
Name: sb_tx_msg_fifo

Overview:
- Sideband TX message FIFO sitting directly upstream of the TX serializer and the credit loop.
- Accepts 64-bit sideband words (headers and data) from the RDI sideband packer.
- Pads every no-data message with a 64-bit all-zero word so that each message occupies 128 bits.
- Feeds the serializer one word per read and flags zero padding words so they are not serialized; credit release keys off this flag.

Parameters:
- DATA_W, 64, word width.
- DEPTH, 32, storage depth in words; must be a power of 2.
- ADDR_W, 5, log2(DEPTH).
- PEND_W, 3, width of the pending-zero counter; maximum 7 outstanding pads.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  write strobe for one word from the packer
- i_wr_data  in  DATA_W  word to store
- i_wr_is_hdr  in  1  word is a message header
- i_wr_has_data  in  1  valid with i_wr_is_hdr; 1 means data words follow, 0 means no-data message
- i_rd_en  in  1  read request from the serializer (serializer done, sampled)
- o_fifo_data  out  DATA_W  registered head word last popped
- o_dont_send_zeros  out  1  popped word is all zeros
- o_empty  out  1  no stored words and no pending pads
- o_full  out  1  word count == DEPTH
- o_count  out  ADDR_W+1  stored words
- o_overflow  out  1  sticky: a word or pad was lost
- o_underflow  out  1  sticky: read attempted while storage was empty

Behaviour:
- Reset values: pointers 0, o_count 0, pend_cnt 0, o_fifo_data 0, o_dont_send_zeros 0, o_empty 1, o_full 0, o_overflow 0, o_underflow 0. Reset mid-operation discards all contents and pending pads immediately.
- Storage: circular buffer with wr_ptr/rd_ptr of ADDR_W bits that wrap modulo DEPTH. o_count is tracked explicitly.
- Write path, per cycle, one storage write maximum:
  - i_wr_en=1 and (not full, or full with an accepted read in the same cycle): store i_wr_data at wr_ptr, wr_ptr+1.
  - i_wr_en=1 and full with no read: word dropped, o_overflow set.
  - i_wr_en=1 with i_wr_is_hdr=1 and i_wr_has_data=0: pend_cnt+1, even if the header itself was dropped.
  - pend_cnt already at max (2^PEND_W-1) when another increment is due: pend_cnt saturates, o_overflow set.
  - i_wr_en=0 and pend_cnt>0 and storage can accept: store 64'b0, pend_cnt-1. A pad never preempts a real write.
  - Resulting ordering for back-to-back no-data headers H1,H2 followed by an idle cycle: H1,H2,0,0.
- Read path:
  - Accepted read: i_rd_en=1 and o_count>0. On the next edge, o_fifo_data <= mem[rd_ptr], rd_ptr+1, and o_dont_send_zeros <= (mem[rd_ptr]==0). Latency is 1 cycle.
  - o_fifo_data and o_dont_send_zeros hold until the next accepted read.
  - i_rd_en=1 with o_count==0: o_fifo_data unchanged, o_underflow set. This applies even if pend_cnt>0, because pads are not readable until written.
- Count: o_count +1 on a write only, -1 on an accepted read only, unchanged when both occur in the same cycle.
- Flags: o_full = (o_count==DEPTH). o_empty = (o_count==0 && pend_cnt==0). Both are registered-state derived, with no combinational path from inputs.
- Sticky flags clear only on reset.

Test Plan:
- Reset then idle: o_empty=1, o_count=0, o_fifo_data=0, all flags 0.
- Write data header 0xA5 (has_data=1), then data word 0x1234, then 2 reads: o_fifo_data = 0xA5 then 0x1234, o_dont_send_zeros=0 both times, o_empty=1 after.
- Two back-to-back no-data headers 0x11, 0x22, then 2 idle cycles, then 4 reads: sequence 0x11, 0x22, 0, 0; o_dont_send_zeros = 0, 0, 1, 1; pend_cnt returns to 0.
- Fill 32 words; write a 33rd with no read: o_full=1, o_overflow=1, count stays 32. Write with a simultaneous read at full: accepted, count stays 32, last word read out correctly after wrap.
- Read when empty: o_underflow=1, o_fifo_data unchanged.
- Assert reset with 5 words and 2 pending pads: all state back to reset values next cycle; subsequent traffic behaves as after the first reset.
